axis_rx_pkt_checker: RTL and testbench
======================================

Name: axis_rx_pkt_checker

Overview:
- Receive-side sink for the UDP/CMAC loopback performance test: consumes the 512-bit AXIS stream from the CMAC RX path (udp clock domain = XDMA axi_aclk).
- Checks every packet against the deterministic pattern the TX generator emits: sequence, length, keep shape and tuser error.
- Keeps good/error packet counters and a throughput window (cycles vs beats) for ILA readout.

Parameters:
DATA_WIDTH, 512, AXIS tdata width (multiple of 32)
KEEP_WIDTH, 64, DATA_WIDTH/8
USER_WIDTH, 1, tuser width; bit 0 = CMAC bad-frame flag
CNT_WIDTH, 32, width of all statistics counters
PERF_BEATS, 65536, accepted beats in one throughput window

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
cfg_enable  in  1  checking enable, level
cfg_pkt_size  in  16  expected packet length in bytes, 1..65535
rx_axis_tvalid  in  1  AXIS valid
rx_axis_tdata  in  DATA_WIDTH  AXIS data
rx_axis_tkeep  in  KEEP_WIDTH  AXIS byte keep
rx_axis_tlast  in  1  AXIS last
rx_axis_tuser  in  USER_WIDTH  AXIS user
rx_axis_tready  out  1  always 1 out of reset (pure sink, never backpressures)
recv_pkt_num  out  CNT_WIDTH  packets checked
err_pkt_num  out  CNT_WIDTH  packets failing any check
total_beat_count  out  CNT_WIDTH  beats accepted while ACTIVE
perf_cycle_count  out  CNT_WIDTH  cycles in the throughput window
perf_beat_count  out  CNT_WIDTH  beats in the throughput window
perf_done  out  1  window complete
is_recv_first_pkt  out  1  first packet seen since enable

Behaviour:
- Reset: rx_axis_tready=0 while RST_N low, then 1. All counters, perf_done and is_recv_first_pkt are 0. Expected sequence is 0. State is IDLE.
- Beat accepted = tvalid & tready.
- Pattern: 32-bit lane i of beat b of packet p = {p[15:0], b[11:0], i[3:0]}. Only keep-enabled bytes are compared.
- FSM states: IDLE, SKIP, ACTIVE, FINISH.
  - IDLE: beats discarded.
  - IDLE, rising edge of cfg_enable: clear all counters, perf_done and expected seq. Go to ACTIVE if no packet is open, else to SKIP.
  - SKIP: discard beats until the tlast beat, then ACTIVE.
  - ACTIVE: check each beat. cfg_enable low mid-packet -> FINISH; at a packet boundary -> IDLE.
  - FINISH: check the remaining beats, count the packet on tlast, then IDLE.
- A per-packet error flag is set by any of:
  - data mismatch;
  - non-last beat with tkeep not all ones;
  - last beat with non-contiguous tkeep (must be 2^k-1, k >= 1);
  - byte count at tlast != cfg_pkt_size (byte count saturates at 0xFFFF);
  - tuser[0]=1 on the tlast beat.
- On the tlast beat in ACTIVE/FINISH: recv_pkt_num+1, plus err_pkt_num+1 if flagged. Both are registered, visible 1 cycle after the handshake. Expected seq += 1 (wraps at 16 bits). is_recv_first_pkt set to 1.
- total_beat_count: +1 per accepted beat in ACTIVE/FINISH.
- Throughput window:
  - Opens on the first accepted beat in ACTIVE. That cycle counts as cycle 1 and beat 1.
  - perf_cycle_count +1 every cycle while open; perf_beat_count +1 per accepted beat.
  - When perf_beat_count reaches PERF_BEATS, both counters freeze and perf_done=1 until the next enable rising edge.
- All counters saturate at 2^CNT_WIDTH-1 (no wrap).
- cfg_pkt_size is sampled at the first beat of each packet; changes mid-packet do not affect that packet.
- Reset mid-packet: all state cleared immediately. The next tlast after enable is treated by the SKIP rule.

Optional Feature:
- Macro: AXIS_RX_CHK_SEQ_RESYNC_EN.
- Defined: on a sequence mismatch in lane 0 of the first beat, the packet counts as an error and expected seq is set to received seq + 1. One lost packet therefore yields exactly 1 error.
- Undefined: expected seq always increments by 1. After a loss, every later packet mismatches.

Decomposition:
- Package axis_rx_chk_pkg holds:
  - width constants (DATA/KEEP/USER defaults, SEQ_W=16, BEAT_IDX_W=12);
  - state enum {IDLE, SKIP, ACTIVE, FINISH};
  - functions keep_popcount(), keep_is_contiguous(), expected_lane().
- One sub-module: axis_rx_chk_pattern. It is combinational and produces the per-byte match vector from (seq, beat_idx, tdata, tkeep).

Test Plan:
- Enable, cfg_pkt_size=256, send 10 good 4-beat packets (seq 0..9) -> recv_pkt_num=10, err_pkt_num=0, total_beat_count=40.
- cfg_pkt_size=100, send one 2-beat packet: beat 1 tkeep all ones, beat 2 tkeep=0xFFFFFFFFF (36 bytes) -> recv=1, err=0. Same packet with last tkeep=0xF0F -> err=1.
- Send seq 0,1,3,4 -> with AXIS_RX_CHK_SEQ_RESYNC_EN: err=1; without: err=2.
- Good packet with tuser=1 on tlast -> err_pkt_num increments by 1, recv_pkt_num by 1.
- PERF_BEATS=16, stream 8 back-to-back 4-beat packets -> perf_beat_count=16, perf_cycle_count=16, perf_done=1, then frozen while total_beat_count reaches 32.
- Raise cfg_enable during the beat 2 of a packet -> that packet is uncounted (SKIP). Drop cfg_enable mid-packet -> the packet is still counted, then IDLE; subsequent beats are ignored.

Source files
------------

// File: rtl/axis_rx_chk_pkg.sv
// axis_rx_chk_pkg
// Shared definitions for the AXIS receive packet checker: default widths,
// the checker state enum and small helpers for tkeep analysis and for
// building the expected 32-bit lane word of the loopback test pattern.
// The tkeep helpers operate on a 64-bit vector. Narrower tkeep buses are
// zero-extended by the caller.
package axis_rx_chk_pkg;

  localparam int DATA_W_DEF = 512;
  localparam int KEEP_W_DEF = 64;
  localparam int USER_W_DEF = 1;
  localparam int KEEP_W_MAX = 64;
  localparam int SEQ_W      = 16;
  localparam int BEAT_IDX_W = 12;
  localparam int LANE_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ACTIVE,
    FINISH
  } chk_state_t;

  // Number of enabled bytes in one beat (0..64)
  function automatic logic [6:0] keep_popcount(input logic [KEEP_W_MAX-1:0] keep);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W_MAX; i++) begin
      n = n + {6'd0, keep[i]};
    end
    return n;
  endfunction

  // True when keep is of the form 2^k-1 with k >= 1 (low bytes only, no holes)
  function automatic logic keep_is_contiguous(input logic [KEEP_W_MAX-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_W_MAX'(1))) == '0);
  endfunction

  // Pattern word carried by lane 'lane' of beat 'beat' in packet 'seq'
  function automatic logic [31:0] expected_lane(input logic [SEQ_W-1:0]      seq,
                                                input logic [BEAT_IDX_W-1:0] beat,
                                                input logic [LANE_IDX_W-1:0] lane);
    return {seq, beat, lane};
  endfunction

endpackage

// File: rtl/axis_rx_chk_pattern.sv
// axis_rx_chk_pattern
// Combinational comparison of one AXIS beat against the loopback test pattern.
// Ports:
//   seq        in   expected packet sequence number
//   beat_idx   in   index of this beat inside the packet
//   tdata      in   received beat data
//   tkeep      in   received byte enables
//   byte_match out  1 per byte that matches or is not enabled
module axis_rx_chk_pattern
  import axis_rx_chk_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [SEQ_W-1:0]      seq,
  input  logic [BEAT_IDX_W-1:0] beat_idx,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic [KEEP_WIDTH-1:0] tkeep,
  output logic [KEEP_WIDTH-1:0] byte_match
);

  localparam int LANES = DATA_WIDTH / 32;

  // Disabled bytes are forced to match so only kept bytes can raise an error
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] exp_word;
    assign exp_word = expected_lane(seq, beat_idx, LANE_IDX_W'(l));
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign byte_match[4*l+b] = ~tkeep[4*l+b] |
                                 (tdata[32*l+8*b +: 8] == exp_word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/axis_rx_pkt_checker.sv
// axis_rx_pkt_checker
// Receive-side sink of the UDP/CMAC loopback test. Accepts every beat, checks
// each packet against the generator pattern (sequence, data, length, keep
// shape, bad-frame flag) and keeps packet, beat and throughput statistics.
// Optional build macro AXIS_RX_CHK_SEQ_RESYNC_EN: after a sequence mismatch on
// the first beat the expected sequence follows the received one.
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   cfg_enable         checking enable (level, rising edge starts a run)
//   cfg_pkt_size       expected packet length in bytes
//   rx_axis_*          AXIS sink interface (tready always 1 out of reset)
//   recv_pkt_num       packets checked
//   err_pkt_num        packets failing any check
//   total_beat_count   beats accepted while checking
//   perf_cycle_count   cycles in the throughput window
//   perf_beat_count    beats in the throughput window
//   perf_done          throughput window complete
//   is_recv_first_pkt  at least one packet checked since enable
module axis_rx_pkt_checker
  import axis_rx_chk_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = USER_W_DEF,
  parameter int CNT_WIDTH  = 32,
  parameter int PERF_BEATS = 65536
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cfg_enable,
  input  logic [15:0]           cfg_pkt_size,
  input  logic                  rx_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic                  rx_axis_tlast,
  input  logic [USER_WIDTH-1:0] rx_axis_tuser,
  output logic                  rx_axis_tready,
  output logic [CNT_WIDTH-1:0]  recv_pkt_num,
  output logic [CNT_WIDTH-1:0]  err_pkt_num,
  output logic [CNT_WIDTH-1:0]  total_beat_count,
  output logic [CNT_WIDTH-1:0]  perf_cycle_count,
  output logic [CNT_WIDTH-1:0]  perf_beat_count,
  output logic                  perf_done,
  output logic                  is_recv_first_pkt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] PERF_TARGET = CNT_WIDTH'(PERF_BEATS);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  chk_state_t            state;
  logic                  enable_q;
  logic                  in_pkt;
  logic [SEQ_W-1:0]      exp_seq;
  logic [SEQ_W-1:0]      next_seq_q;
  logic [BEAT_IDX_W-1:0] beat_idx_q;
  logic [15:0]           byte_cnt_q;
  logic [15:0]           pkt_size_q;
  logic                  err_q;
  logic                  perf_open;

  logic                  accept, start, checking, check_beat, first_beat, pkt_open_next;
  logic [BEAT_IDX_W-1:0] beat_idx_c;
  logic [15:0]           size_c, byte_cnt_c;
  logic [16:0]           byte_sum;
  logic [KEEP_W_MAX-1:0] keep_ext;
  logic [KEEP_WIDTH-1:0] byte_match;
  logic                  data_err, shape_err, len_err, user_err, seq_err, err_now;
  logic [SEQ_W-1:0]      seq_follow, next_seq_c;

  assign accept        = rx_axis_tvalid & rx_axis_tready;
  assign start         = (state == IDLE) & cfg_enable & ~enable_q;
  assign checking      = (state == ACTIVE) || (state == FINISH);
  assign check_beat    = checking & accept;
  // in_pkt follows the wire in every state, so it tells whether a packet is open
  assign first_beat    = ~in_pkt;
  assign pkt_open_next = accept ? ~rx_axis_tlast : in_pkt;

  assign beat_idx_c = first_beat ? '0 : beat_idx_q;
  assign size_c     = first_beat ? cfg_pkt_size : pkt_size_q;
  assign keep_ext   = KEEP_W_MAX'(rx_axis_tkeep);
  assign byte_sum   = {1'b0, (first_beat ? 16'd0 : byte_cnt_q)} + {10'd0, keep_popcount(keep_ext)};
  assign byte_cnt_c = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

  axis_rx_chk_pattern #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_pattern (
    .seq       (exp_seq),
    .beat_idx  (beat_idx_c),
    .tdata     (rx_axis_tdata),
    .tkeep     (rx_axis_tkeep),
    .byte_match(byte_match)
  );

  assign data_err  = ~&byte_match;
  assign shape_err = rx_axis_tlast ? ~keep_is_contiguous(keep_ext) : ~&rx_axis_tkeep;
  assign len_err   = rx_axis_tlast & (byte_cnt_c != size_c);
  assign user_err  = rx_axis_tlast & rx_axis_tuser[0];

`ifdef AXIS_RX_CHK_SEQ_RESYNC_EN
  logic [SEQ_W-1:0] rx_seq;
  assign rx_seq     = rx_axis_tdata[31:16];
  assign seq_err    = first_beat & (rx_seq != exp_seq);
  assign seq_follow = seq_err ? rx_seq + SEQ_W'(1) : exp_seq + SEQ_W'(1);
`else
  assign seq_err    = 1'b0;
  assign seq_follow = exp_seq + SEQ_W'(1);
`endif

  // The follow-on sequence is decided on the first beat and held for the packet
  assign next_seq_c = first_beat ? seq_follow : next_seq_q;
  assign err_now    = (first_beat ? 1'b0 : err_q) | data_err | shape_err |
                      len_err | user_err | seq_err;

  // Checker state machine; a run starts only on an enable rising edge in IDLE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      enable_q       <= 1'b0;
      rx_axis_tready <= 1'b0;
    end else begin
      enable_q       <= cfg_enable;
      rx_axis_tready <= 1'b1;
      case (state)
        IDLE:    if (start) state <= pkt_open_next ? SKIP : ACTIVE;
        SKIP:    if (!cfg_enable) state <= IDLE;
                 else if (accept && rx_axis_tlast) state <= ACTIVE;
        ACTIVE:  if (!cfg_enable) state <= pkt_open_next ? FINISH : IDLE;
        FINISH:  if (accept && rx_axis_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-packet tracking: beat index, byte count, sampled size, error flag, sequence
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_pkt     <= 1'b0;
      exp_seq    <= '0;
      next_seq_q <= '0;
      beat_idx_q <= '0;
      byte_cnt_q <= '0;
      pkt_size_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) in_pkt <= ~rx_axis_tlast;
      if (start) begin
        exp_seq <= '0;
      end else if (check_beat) begin
        beat_idx_q <= beat_idx_c + BEAT_IDX_W'(1);
        byte_cnt_q <= byte_cnt_c;
        pkt_size_q <= size_c;
        err_q      <= err_now;
        next_seq_q <= next_seq_c;
        if (rx_axis_tlast) exp_seq <= next_seq_c;
      end
    end
  end

  // Packet and beat statistics
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      recv_pkt_num      <= '0;
      err_pkt_num       <= '0;
      total_beat_count  <= '0;
      is_recv_first_pkt <= 1'b0;
    end else if (start) begin
      recv_pkt_num      <= '0;
      err_pkt_num       <= '0;
      total_beat_count  <= '0;
      is_recv_first_pkt <= 1'b0;
    end else if (check_beat) begin
      total_beat_count <= sat_inc(total_beat_count);
      if (rx_axis_tlast) begin
        recv_pkt_num      <= sat_inc(recv_pkt_num);
        is_recv_first_pkt <= 1'b1;
        if (err_now) err_pkt_num <= sat_inc(err_pkt_num);
      end
    end
  end

  // Throughput window: opens on the first checked beat, freezes at PERF_BEATS beats
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_cycle_count <= '0;
      perf_beat_count  <= '0;
      perf_done        <= 1'b0;
      perf_open        <= 1'b0;
    end else if (start) begin
      perf_cycle_count <= '0;
      perf_beat_count  <= '0;
      perf_done        <= 1'b0;
      perf_open        <= 1'b0;
    end else if (perf_open) begin
      perf_cycle_count <= sat_inc(perf_cycle_count);
      if (check_beat) begin
        perf_beat_count <= sat_inc(perf_beat_count);
        if (sat_inc(perf_beat_count) == PERF_TARGET) begin
          perf_done <= 1'b1;
          perf_open <= 1'b0;
        end
      end
    end else if (!perf_done && (state == ACTIVE) && accept) begin
      perf_cycle_count <= CNT_WIDTH'(1);
      perf_beat_count  <= CNT_WIDTH'(1);
      if (PERF_TARGET == CNT_WIDTH'(1)) perf_done <= 1'b1;
      else perf_open <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_rx_pkt_checker.sv
// tb_axis_rx_pkt_checker
// Self-checking bench for axis_rx_pkt_checker (PERF_BEATS=16). Each packet
// that should be counted pushes its expected counter values to a scoreboard;
// a monitor pops and compares whenever recv_pkt_num moves.
// Honours AXIS_RX_CHK_SEQ_RESYNC_EN in its sequence model.
module tb_axis_rx_pkt_checker;

  logic         CLK;
  logic         RST_N;
  logic         cfg_enable;
  logic [15:0]  cfg_pkt_size;
  logic         rx_axis_tvalid;
  logic [511:0] rx_axis_tdata;
  logic [63:0]  rx_axis_tkeep;
  logic         rx_axis_tlast;
  logic [0:0]   rx_axis_tuser;
  logic         rx_axis_tready;
  logic [31:0]  recv_pkt_num, err_pkt_num, total_beat_count;
  logic [31:0]  perf_cycle_count, perf_beat_count;
  logic         perf_done, is_recv_first_pkt;

  typedef struct {
    int unsigned recv;
    int unsigned err;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_item;
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_recv = 0;
  int unsigned exp_err = 0;
  int unsigned mon_last = 0;
  logic [15:0] model_seq = '0;
  int          pkt_size = 256;

`ifdef AXIS_RX_CHK_SEQ_RESYNC_EN
  localparam int GAP_ERRS = 1;
`else
  localparam int GAP_ERRS = 2;
`endif

  axis_rx_pkt_checker #(
    .DATA_WIDTH(512),
    .KEEP_WIDTH(64),
    .USER_WIDTH(1),
    .CNT_WIDTH (32),
    .PERF_BEATS(16)
  ) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .cfg_enable       (cfg_enable),
    .cfg_pkt_size     (cfg_pkt_size),
    .rx_axis_tvalid   (rx_axis_tvalid),
    .rx_axis_tdata    (rx_axis_tdata),
    .rx_axis_tkeep    (rx_axis_tkeep),
    .rx_axis_tlast    (rx_axis_tlast),
    .rx_axis_tuser    (rx_axis_tuser),
    .rx_axis_tready   (rx_axis_tready),
    .recv_pkt_num     (recv_pkt_num),
    .err_pkt_num      (err_pkt_num),
    .total_beat_count (total_beat_count),
    .perf_cycle_count (perf_cycle_count),
    .perf_beat_count  (perf_beat_count),
    .perf_done        (perf_done),
    .is_recv_first_pkt(is_recv_first_pkt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Trailing-ones count followed by an all-zero remainder
  function automatic bit keep_contig(input logic [63:0] k);
    int n = 0;
    while (n < 64 && k[n]) n++;
    for (int i = n; i < 64; i++) if (k[i]) return 1'b0;
    return n > 0;
  endfunction

  task automatic resetModel();
    model_seq = '0;
    exp_recv  = 0;
    exp_err   = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tuser  = '0;
    end
  endtask

  task automatic startChecking(input int size);
    @(negedge CLK);
    cfg_enable   = 1'b0;
    cfg_pkt_size = 16'(size);
    pkt_size     = size;
    idleCycles(2);
    resetModel();
    @(negedge CLK);
    cfg_enable = 1'b1;
    idleCycles(2);
  endtask

  // corrupt: 0 none, 1 flip a data bit in beat 0 lane 3, 2 keep hole in beat 0
  task automatic applyStimulus(input logic [15:0] seq, input int nbeats, input logic [63:0] last_keep,
                               input bit user_last, input int corrupt, input bit counted,
                               input int enable_at, input int disable_at);
    bit err;
    int bytes;
    if (counted) begin
      bytes = (nbeats - 1) * 64 + $countones(last_keep) - ((corrupt == 2) ? 1 : 0);
      err = (corrupt != 0) || user_last || !keep_contig(last_keep) ||
            (bytes != pkt_size) || (seq != model_seq);
`ifdef AXIS_RX_CHK_SEQ_RESYNC_EN
      model_seq = (seq != model_seq) ? seq + 16'd1 : model_seq + 16'd1;
`else
      model_seq = model_seq + 16'd1;
`endif
      exp_recv++;
      if (err) exp_err++;
      sb_q.push_back('{exp_recv, exp_err});
    end
    for (int b = 0; b < nbeats; b++) begin
      @(negedge CLK);
      if (b == enable_at) cfg_enable = 1'b1;
      if (b == disable_at) cfg_enable = 1'b0;
      rx_axis_tvalid = 1'b1;
      for (int l = 0; l < 16; l++) rx_axis_tdata[32*l +: 32] = {seq, 12'(b), 4'(l)};
      rx_axis_tkeep = '1;
      rx_axis_tlast = 1'b0;
      rx_axis_tuser = '0;
      if (b == 0 && corrupt == 1) rx_axis_tdata[100] = ~rx_axis_tdata[100];
      if (b == 0 && corrupt == 2) rx_axis_tkeep[5] = 1'b0;
      if (b == nbeats - 1) begin
        rx_axis_tkeep = last_keep;
        rx_axis_tlast = 1'b1;
        rx_axis_tuser = user_last;
        for (int j = 0; j < 64; j++) if (!last_keep[j]) rx_axis_tdata[8*j +: 8] = 8'hAA;
      end
    end
  endtask

  // Scoreboard monitor: a return to zero is a run restart, any rise pops one entry
  always @(negedge CLK) begin
    if (RST_N && (recv_pkt_num != mon_last)) begin
      if (recv_pkt_num == 0) begin
        mon_last = 0;
      end else if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_pkt", recv_pkt_num, mon_last);
        mon_last = recv_pkt_num;
      end else begin
        sb_item = sb_q.pop_front();
        checkOutput("sb_recv", recv_pkt_num, sb_item.recv);
        checkOutput("sb_err", err_pkt_num, sb_item.err);
        mon_last = recv_pkt_num;
      end
    end
  end

  initial begin
    RST_N          = 1'b0;
    cfg_enable     = 1'b0;
    cfg_pkt_size   = 16'd256;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = '0;
    rx_axis_tkeep  = '0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_tready_low", rx_axis_tready, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("reset_tready_high", rx_axis_tready, 1);
    checkOutput("reset_recv", recv_pkt_num, 0);
    checkOutput("reset_err", err_pkt_num, 0);
    checkOutput("reset_total", total_beat_count, 0);
    checkOutput("reset_perf_cycle", perf_cycle_count, 0);
    checkOutput("reset_perf_beat", perf_beat_count, 0);
    checkOutput("reset_perf_done", perf_done, 0);
    checkOutput("reset_first_pkt", is_recv_first_pkt, 0);

    // Ten good back-to-back packets; the 16-beat window closes inside them
    startChecking(256);
    for (int i = 0; i < 10; i++) applyStimulus(16'(i), 4, '1, 1'b0, 0, 1'b1, -1, -1);
    idleCycles(6);
    checkOutput("good_recv", recv_pkt_num, 10);
    checkOutput("good_err", err_pkt_num, 0);
    checkOutput("good_total", total_beat_count, 40);
    checkOutput("good_perf_beat", perf_beat_count, 16);
    checkOutput("good_perf_cycle", perf_cycle_count, 16);
    checkOutput("good_perf_done", perf_done, 1);
    checkOutput("good_first_pkt", is_recv_first_pkt, 1);
    checkOutput("good_drained", sb_q.size(), 0);

    // Length, keep shape, data, tuser and keep-hole errors at 100-byte packets
    startChecking(100);
    checkOutput("restart_perf_done", perf_done, 0);
    applyStimulus(16'd0, 2, 64'hF_FFFF_FFFF, 1'b0, 0, 1'b1, -1, -1);
    applyStimulus(16'd1, 2, 64'hF0F, 1'b0, 0, 1'b1, -1, -1);
    applyStimulus(16'd2, 2, 64'hF_FFFF_FFFF, 1'b0, 1, 1'b1, -1, -1);
    applyStimulus(16'd3, 2, 64'hF_FFFF_FFFF, 1'b1, 0, 1'b1, -1, -1);
    applyStimulus(16'd4, 2, 64'hF_FFFF_FFFF, 1'b0, 2, 1'b1, -1, -1);
    applyStimulus(16'd5, 2, 64'hF_FFFF_FFFF, 1'b0, 0, 1'b1, -1, -1);
    idleCycles(6);
    checkOutput("err_recv", recv_pkt_num, 6);
    checkOutput("err_err", err_pkt_num, 4);
    checkOutput("err_perf_beat", perf_beat_count, 12);
    checkOutput("err_perf_done", perf_done, 0);
    checkOutput("err_drained", sb_q.size(), 0);

    // One lost packet in the sequence
    startChecking(256);
    applyStimulus(16'd0, 4, '1, 1'b0, 0, 1'b1, -1, -1);
    applyStimulus(16'd1, 4, '1, 1'b0, 0, 1'b1, -1, -1);
    applyStimulus(16'd3, 4, '1, 1'b0, 0, 1'b1, -1, -1);
    applyStimulus(16'd4, 4, '1, 1'b0, 0, 1'b1, -1, -1);
    idleCycles(6);
    checkOutput("gap_recv", recv_pkt_num, 4);
    checkOutput("gap_err", err_pkt_num, GAP_ERRS);
    checkOutput("gap_drained", sb_q.size(), 0);

    // Enable raised mid-packet, then dropped mid-packet
    @(negedge CLK);
    cfg_enable = 1'b0;
    idleCycles(3);
    resetModel();
    applyStimulus(16'h0077, 4, '1, 1'b0, 0, 1'b0, 1, -1);
    applyStimulus(16'd0, 4, '1, 1'b0, 0, 1'b1, -1, -1);
    applyStimulus(16'd1, 4, '1, 1'b0, 0, 1'b1, -1, 1);
    applyStimulus(16'd2, 4, '1, 1'b0, 0, 1'b0, -1, -1);
    idleCycles(6);
    checkOutput("edge_recv", recv_pkt_num, 2);
    checkOutput("edge_err", err_pkt_num, 0);
    checkOutput("edge_total", total_beat_count, 8);
    checkOutput("edge_perf_beat", perf_beat_count, 8);
    checkOutput("edge_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
